// File: rtl/bf_sequencer.sv
// bf_sequencer: fetch/decode/execute sequencer for a Brainfuck program ROM.
// It drives a tape block (pointer counter and cell RAM) and moves bytes
// to and from the host over valid/ready handshakes.
//
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   start                  pulse in IDLE to begin execution at pc=0
//   prog_addr / prog_data  program ROM address (registered) and opcode byte
//   ptr_c / ptr_dir        pointer step pulse, direction (0 = '>', 1 = '<')
//   cell_rd / cell_q       cell read request, current cell value
//   cell_we / cell_d       cell write strobe and data
//   out_valid/out_ready/out_data   output byte handshake ('.')
//   in_valid/in_ready/in_data      input byte handshake (',')
//   busy / halted / error  status; error is sticky until reset
module bf_sequencer #(
  parameter int PC_W    = 8,
  parameter int DEPTH_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [PC_W-1:0] prog_addr,
  input  logic [7:0]      prog_data,
  output logic            ptr_c,
  output logic            ptr_dir,
  output logic            cell_rd,
  input  logic [7:0]      cell_q,
  output logic            cell_we,
  output logic [7:0]      cell_d,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [7:0]      out_data,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [7:0]      in_data,
  output logic            busy,
  output logic            halted,
  output logic            error
);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_READ, S_OUT_WAIT,
    S_IN_WAIT, S_SCAN_F, S_SCAN_B, S_HALT
  } state_t;

  localparam logic [7:0] OP_RIGHT = 8'h3E;
  localparam logic [7:0] OP_LEFT  = 8'h3C;
  localparam logic [7:0] OP_INC   = 8'h2B;
  localparam logic [7:0] OP_DEC   = 8'h2D;
  localparam logic [7:0] OP_OUT   = 8'h2E;
  localparam logic [7:0] OP_IN    = 8'h2C;
  localparam logic [7:0] OP_OPEN  = 8'h5B;
  localparam logic [7:0] OP_CLOSE = 8'h5D;
  localparam logic [7:0] OP_HALT  = 8'h00;

  localparam logic [PC_W-1:0]    PC_MAX    = '1;
  localparam logic [DEPTH_W-1:0] DEPTH_MAX = '1;
  localparam logic [DEPTH_W-1:0] DEPTH_ONE = DEPTH_W'(1);

  state_t             state;
  logic [PC_W-1:0]    pc;
  logic [DEPTH_W-1:0] depth;
  logic               scan_ph;
  logic [7:0]         op;

  logic               pc_last;
  logic [7:0]         nest_op;
  logic [7:0]         match_op;
  logic               scan_edge;

  function automatic logic [7:0] byte_inc(input logic [7:0] b);
    return b + 8'd1;
  endfunction

  function automatic logic [7:0] byte_dec(input logic [7:0] b);
    return b - 8'd1;
  endfunction

  assign pc_last = (pc == PC_MAX);
  assign busy    = (state != S_IDLE) && (state != S_HALT);
  assign halted  = (state == S_HALT);

  // Scan direction decides which bracket nests deeper, which one closes the
  // loop, and which end of program memory is out of bounds.
  always_comb begin
    nest_op   = OP_OPEN;
    match_op  = OP_CLOSE;
    scan_edge = (pc == PC_MAX);
    if (state == S_SCAN_B) begin
      nest_op   = OP_CLOSE;
      match_op  = OP_OPEN;
      scan_edge = (pc == '0);
    end
  end

  // Opcode held for the READ state; pure data, no reset needed.
  always_ff @(posedge clk) begin
    if (state == S_DECODE) op <= prog_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      pc        <= '0;
      depth     <= '0;
      scan_ph   <= 1'b0;
      prog_addr <= '0;
      ptr_c     <= 1'b0;
      ptr_dir   <= 1'b0;
      cell_rd   <= 1'b0;
      cell_we   <= 1'b0;
      cell_d    <= 8'h00;
      out_valid <= 1'b0;
      out_data  <= 8'h00;
      in_ready  <= 1'b0;
      error     <= 1'b0;
    end else begin
      ptr_c   <= 1'b0;
      cell_rd <= 1'b0;
      cell_we <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            pc    <= '0;
            depth <= '0;
            state <= S_FETCH;
          end
        end
        // fetch: present pc to program memory
        S_FETCH: begin
          prog_addr <= pc;
          state     <= S_DECODE;
        end
        // decode: opcode byte is valid now
        S_DECODE: begin
          case (prog_data)
            OP_RIGHT, OP_LEFT: begin
              ptr_c   <= 1'b1;
              ptr_dir <= (prog_data == OP_LEFT);
              if (pc_last) state <= S_HALT;
              else begin
                pc    <= pc + 1'b1;
                state <= S_FETCH;
              end
            end
            OP_INC, OP_DEC, OP_OUT, OP_OPEN, OP_CLOSE: begin
              cell_rd <= 1'b1;
              state   <= S_READ;
            end
            OP_IN: begin
              in_ready <= 1'b1;
              state    <= S_IN_WAIT;
            end
            OP_HALT: state <= S_HALT;
            default: begin
              if (pc_last) state <= S_HALT;
              else begin
                pc    <= pc + 1'b1;
                state <= S_FETCH;
              end
            end
          endcase
        end
        // read: cell value is valid, execute the cell opcode
        S_READ: begin
          if (op == OP_OUT) begin
            out_valid <= 1'b1;
            out_data  <= cell_q;
            state     <= S_OUT_WAIT;
          end else if (op == OP_OPEN && cell_q == 8'h00) begin
            depth <= DEPTH_ONE;
            if (pc_last) begin
              error <= 1'b1;
              state <= S_HALT;
            end else begin
              pc      <= pc + 1'b1;
              scan_ph <= 1'b0;
              state   <= S_SCAN_F;
            end
          end else if (op == OP_CLOSE && cell_q != 8'h00) begin
            depth <= DEPTH_ONE;
            if (pc == '0) begin
              error <= 1'b1;
              state <= S_HALT;
            end else begin
              pc      <= pc - 1'b1;
              scan_ph <= 1'b0;
              state   <= S_SCAN_B;
            end
          end else begin
            if (op == OP_INC || op == OP_DEC) begin
              cell_we <= 1'b1;
              cell_d  <= (op == OP_INC) ? byte_inc(cell_q) : byte_dec(cell_q);
            end
            if (pc_last) state <= S_HALT;
            else begin
              pc    <= pc + 1'b1;
              state <= S_FETCH;
            end
          end
        end
        S_OUT_WAIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (pc_last) state <= S_HALT;
            else begin
              pc    <= pc + 1'b1;
              state <= S_FETCH;
            end
          end
        end
        S_IN_WAIT: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            cell_we  <= 1'b1;
            cell_d   <= in_data;
            if (pc_last) state <= S_HALT;
            else begin
              pc    <= pc + 1'b1;
              state <= S_FETCH;
            end
          end
        end
        // scan: phase 0 addresses the byte, phase 1 compares it
        S_SCAN_F, S_SCAN_B: begin
          if (!scan_ph) begin
            prog_addr <= pc;
            scan_ph   <= 1'b1;
          end else begin
            scan_ph <= 1'b0;
            if (prog_data == nest_op && depth == DEPTH_MAX) begin
              error <= 1'b1;
              state <= S_HALT;
            end else if (prog_data == match_op && depth == DEPTH_ONE) begin
              depth <= '0;
              if (pc_last) state <= S_HALT;
              else begin
                pc    <= pc + 1'b1;
                state <= S_FETCH;
              end
            end else begin
              if (prog_data == nest_op) depth <= depth + 1'b1;
              else if (prog_data == match_op) depth <= depth - 1'b1;
              if (scan_edge) begin
                error <= 1'b1;
                state <= S_HALT;
              end else if (state == S_SCAN_F) pc <= pc + 1'b1;
              else pc <= pc - 1'b1;
            end
          end
        end
        S_HALT: state <= S_HALT;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bf_sequencer.sv
// tb_bf_sequencer: table-driven and randomized bench for bf_sequencer.
// Program ROM and tape are modelled around the DUT; a Brainfuck
// interpreter inside the bench predicts output bytes, cell writes,
// pointer moves and the error/halt outcome.
module tb_bf_sequencer;

  localparam int BUDGET = 12000;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] prog_addr;
  logic [7:0] prog_data;
  logic       ptr_c;
  logic       ptr_dir;
  logic       cell_rd;
  logic [7:0] cell_q;
  logic       cell_we;
  logic [7:0] cell_d;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       busy;
  logic       halted;
  logic       error;

  bf_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .prog_addr(prog_addr), .prog_data(prog_data),
    .ptr_c(ptr_c), .ptr_dir(ptr_dir),
    .cell_rd(cell_rd), .cell_q(cell_q),
    .cell_we(cell_we), .cell_d(cell_d),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .busy(busy), .halted(halted), .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // program ROM and tape around the DUT
  logic [7:0] rom [256];
  logic [7:0] tape [256];
  logic [7:0] tptr;
  logic       tape_clr;

  assign prog_data = rom[prog_addr];
  assign cell_q    = tape[tptr];

  always @(posedge clk) begin
    if (tape_clr) begin
      tptr <= 8'h00;
      for (int k = 0; k < 256; k++) tape[k] <= 8'h00;
    end else begin
      if (cell_we) tape[tptr] <= cell_d;
      if (ptr_c) tptr <= ptr_dir ? tptr - 8'd1 : tptr + 8'd1;
    end
  end

  int n_cmp;
  int n_fail;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // observed DUT activity
  logic [7:0] d_out [$];
  logic [7:0] d_wr [$];
  logic       d_dir [$];
  int         d_we_cyc [$];
  int         excl_viol;
  int         stall_left;
  logic [7:0] in_bytes [$];

  // reference interpreter results
  logic [7:0] m_out [$];
  logic [7:0] m_wr [$];
  logic       m_dir [$];
  bit         m_err;
  bit         m_ok;
  logic [7:0] m_pc;

  task automatic ref_run();
    logic [7:0] mt [256];
    logic [7:0] pc, ptr, p, c;
    int d, steps, inidx;
    bit done;
    m_out.delete(); m_wr.delete(); m_dir.delete();
    for (int k = 0; k < 256; k++) mt[k] = 8'h00;
    pc = 8'h00; ptr = 8'h00; steps = 0; inidx = 0; done = 0;
    m_err = 0; m_ok = 1; m_pc = 8'h00;
    while (!done && m_ok) begin
      steps++;
      if (steps > 200) m_ok = 0;
      c = rom[pc];
      if (c == 8'h00) begin
        done = 1;
      end else begin
        case (c)
          8'h3E: begin ptr = ptr + 8'd1; m_dir.push_back(1'b0); end
          8'h3C: begin ptr = ptr - 8'd1; m_dir.push_back(1'b1); end
          8'h2B: begin mt[ptr] = mt[ptr] + 8'd1; m_wr.push_back(mt[ptr]); end
          8'h2D: begin mt[ptr] = mt[ptr] - 8'd1; m_wr.push_back(mt[ptr]); end
          8'h2E: m_out.push_back(mt[ptr]);
          8'h2C: begin
            if (inidx >= in_bytes.size()) m_ok = 0;
            else begin
              mt[ptr] = in_bytes[inidx]; inidx++;
              m_wr.push_back(mt[ptr]);
            end
          end
          8'h5B: if (mt[ptr] == 8'h00) begin
            d = 1; p = pc;
            while (d != 0 && !m_err) begin
              if (p == 8'hFF) m_err = 1;
              else begin
                p = p + 8'd1;
                if (rom[p] == 8'h5B) begin d++; if (d > 15) m_err = 1; end
                else if (rom[p] == 8'h5D) d--;
              end
            end
            pc = p;
          end
          8'h5D: if (mt[ptr] != 8'h00) begin
            d = 1; p = pc;
            while (d != 0 && !m_err) begin
              if (p == 8'h00) m_err = 1;
              else begin
                p = p - 8'd1;
                if (rom[p] == 8'h5D) begin d++; if (d > 15) m_err = 1; end
                else if (rom[p] == 8'h5B) d--;
              end
            end
            pc = p;
          end
          default: ;
        endcase
        if (m_err) done = 1;
        else if (pc == 8'hFF) done = 1;
        else pc = pc + 8'd1;
      end
    end
    m_pc = pc;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; out_ready = 1'b0;
    in_valid = 1'b0; in_data = 8'h00; tape_clr = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_dut(input int stall, input bit rnd, input logic [7:0] stall_exp);
    int cyc;
    int in_idx;
    d_out.delete(); d_wr.delete(); d_dir.delete(); d_we_cyc.delete();
    excl_viol = 0; stall_left = stall; in_idx = 0;
    do_reset();
    chk("reset_outputs", 32'(|{prog_addr, ptr_c, ptr_dir, cell_rd, cell_we, cell_d,
        out_valid, out_data, in_ready, busy, halted, error}), 0);
    rst_n = 1'b1; tape_clr = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!halted && cyc < BUDGET) begin
      @(negedge clk);
      cyc++;
      if (cell_we) begin d_wr.push_back(cell_d); d_we_cyc.push_back(cyc); end
      if (ptr_c) d_dir.push_back(ptr_dir);
      if (int'(ptr_c) + int'(cell_rd) + int'(cell_we) > 1) excl_viol++;
      if (rnd) out_ready = ($urandom_range(0, 1) == 1);
      else if (out_valid && stall_left > 0) begin
        chk("stall_data", 32'(out_data), 32'(stall_exp));
        chk("stall_quiet", 32'(ptr_c | cell_rd | cell_we), 0);
        stall_left--;
        out_ready = 1'b0;
      end else out_ready = 1'b1;
      in_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_data  = (in_idx < in_bytes.size()) ? in_bytes[in_idx] : 8'h00;
      // the coming edge completes whichever handshakes are set up now
      if (out_valid && out_ready) d_out.push_back(out_data);
      if (in_valid && in_ready) in_idx++;
    end
    chk("halt_reached", 32'(halted), 1);
    chk("exclusive_pulses", 32'(excl_viol), 0);
  endtask

  typedef struct packed {
    logic [8*20-1:0] prog;
    logic [7:0]      inb;
    int              stall;
    int              nout;
    logic [7:0]      o0;
    logic [7:0]      o1;
    bit              err;
  } vec_t;

  function automatic vec_t mk(input string p, input logic [7:0] inb, input int stall,
                              input int nout, input logic [7:0] o0, input logic [7:0] o1,
                              input bit err);
    vec_t v;
    v.prog = '0;
    for (int i = 0; i < p.len() && i < 20; i++) v.prog[8*(19-i) +: 8] = p[i];
    v.inb = inb; v.stall = stall; v.nout = nout;
    v.o0 = o0; v.o1 = o1; v.err = err;
    return v;
  endfunction

  vec_t       vecs [10];
  logic [7:0] alpha [8];

  initial begin
    n_cmp = 0; n_fail = 0;
    rst_n = 1'b0; start = 1'b0; out_ready = 1'b0;
    in_valid = 1'b0; in_data = 8'h00; tape_clr = 1'b1;
    for (int k = 0; k < 256; k++) rom[k] = 8'h00;

    vecs[0] = mk("+++.",             8'h00, 0, 1, 8'h03, 8'h00, 0);
    vecs[1] = mk("->+<.",            8'h00, 0, 1, 8'hFF, 8'h00, 0);
    vecs[2] = mk("[+.]",             8'h00, 0, 0, 8'h00, 8'h00, 0);
    vecs[3] = mk("++[-.]",           8'h00, 0, 2, 8'h01, 8'h00, 0);
    vecs[4] = mk("++[-.]",           8'h00, 5, 2, 8'h01, 8'h00, 0);
    vecs[5] = mk("+]",               8'h00, 0, 0, 8'h00, 8'h00, 1);
    vecs[6] = mk(",.",               8'h5A, 0, 1, 8'h5A, 8'h00, 0);
    vecs[7] = mk("[[[[[[[[[[[[[[[[", 8'h00, 0, 0, 8'h00, 8'h00, 1);
    vecs[8] = mk("[",                8'h00, 0, 0, 8'h00, 8'h00, 1);
    vecs[9] = mk("-.+.",             8'h00, 0, 2, 8'hFF, 8'h00, 0);

    for (int i = 0; i < 10; i++) begin
      for (int k = 0; k < 256; k++) rom[k] = (k < 20) ? vecs[i].prog[8*(19-k) +: 8] : 8'h00;
      in_bytes.delete();
      in_bytes.push_back(vecs[i].inb);
      run_dut(vecs[i].stall, 1'b0, vecs[i].o0);
      chk("out_count", 32'(d_out.size()), 32'(vecs[i].nout));
      if (vecs[i].nout > 0 && d_out.size() > 0) chk("out_byte0", 32'(d_out[0]), 32'(vecs[i].o0));
      if (vecs[i].nout > 1 && d_out.size() > 1) chk("out_byte1", 32'(d_out[1]), 32'(vecs[i].o1));
      chk("error_flag", 32'(error), 32'(vecs[i].err));
      if (vecs[i].stall > 0) chk("stall_cycles", 32'(stall_left), 0);

      if (i == 0) begin
        if (d_we_cyc.size() >= 3) begin
          chk("inc_spacing_a", 32'(d_we_cyc[1] - d_we_cyc[0]), 3);
          chk("inc_spacing_b", 32'(d_we_cyc[2] - d_we_cyc[1]), 3);
        end else chk("inc_write_count", 32'(d_we_cyc.size()), 3);
        // HALT must ignore start
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("halt_ignores_start", 32'({halted, busy}), 32'h2);
      end
      if (i == 1) begin
        chk("wr_count", 32'(d_wr.size()), 2);
        chk("dir_count", 32'(d_dir.size()), 2);
        if (d_wr.size() >= 2) begin
          chk("wr_dec_wrap", 32'(d_wr[0]), 32'hFF);
          chk("wr_inc", 32'(d_wr[1]), 32'h01);
        end
        if (d_dir.size() >= 2) begin
          chk("dir_right", 32'(d_dir[0]), 0);
          chk("dir_left", 32'(d_dir[1]), 1);
        end
      end
      if (i == 2) begin
        chk("skip_no_write", 32'(d_wr.size()), 0);
        chk("skip_exit_pc", 32'(prog_addr), 4);
      end
      if (i == 4) chk("stall_wr_count", 32'(d_wr.size()), 4);
    end

    // reset while waiting for an input byte
    for (int k = 0; k < 256; k++) rom[k] = 8'h00;
    rom[0] = 8'h2C;
    do_reset();
    rst_n = 1'b1; tape_clr = 1'b0; out_ready = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 20 && !in_ready; c++) @(negedge clk);
    chk("in_wait_reached", 32'(in_ready), 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_in_wait_outputs", 32'(|{prog_addr, ptr_c, ptr_dir, cell_rd, cell_we, cell_d,
        out_valid, out_data, in_ready, busy, halted, error}), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_after_reset", 32'({busy, halted}), 0);

    // randomized programs against the reference interpreter
    alpha[0] = 8'h2B; alpha[1] = 8'h2D; alpha[2] = 8'h3E; alpha[3] = 8'h3C;
    alpha[4] = 8'h2E; alpha[5] = 8'h2C; alpha[6] = 8'h5B; alpha[7] = 8'h5D;
    for (int r = 0; r < 10; r++) begin
      int tries;
      tries = 0;
      m_ok = 0;
      while (!m_ok && tries < 50) begin
        int len;
        len = $urandom_range(3, 12);
        for (int k = 0; k < 256; k++) rom[k] = 8'h00;
        for (int k = 0; k < len; k++) rom[k] = alpha[$urandom_range(0, 7)];
        in_bytes.delete();
        for (int k = 0; k < 16; k++) in_bytes.push_back(8'($urandom));
        ref_run();
        tries++;
      end
      if (!m_ok) begin
        for (int k = 0; k < 256; k++) rom[k] = 8'h00;
        rom[0] = 8'h2B; rom[1] = 8'h2E;
        ref_run();
      end
      run_dut(0, 1'b1, 8'h00);
      chk("rnd_out_count", 32'(d_out.size()), 32'(m_out.size()));
      for (int k = 0; k < m_out.size() && k < d_out.size(); k++)
        chk("rnd_out_byte", 32'(d_out[k]), 32'(m_out[k]));
      chk("rnd_wr_count", 32'(d_wr.size()), 32'(m_wr.size()));
      for (int k = 0; k < m_wr.size() && k < d_wr.size(); k++)
        chk("rnd_wr_data", 32'(d_wr[k]), 32'(m_wr[k]));
      chk("rnd_dir_count", 32'(d_dir.size()), 32'(m_dir.size()));
      for (int k = 0; k < m_dir.size() && k < d_dir.size(); k++)
        chk("rnd_dir", 32'(d_dir[k]), 32'(m_dir[k]));
      chk("rnd_error", 32'(error), 32'(m_err));
      if (!m_err) chk("rnd_halt_pc", 32'(prog_addr), 32'(m_pc));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
